// File: rtl/rom_reader_if.sv
// Command, ROM-side and stream-side signals of the rom_reader sequencer.
// The slave modport is the sequencer's view; the master modport is its environment.
interface rom_reader_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport slave (
        input  start, base_addr, count, rom_data, out_ready,
        output busy, done, rom_en, rom_addr, out_valid, out_data, out_last
    );

    modport master (
        output start, base_addr, count, rom_data, out_ready,
        input  busy, done, rom_en, rom_addr, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rom_reader.sv
// Sweeps a wrapping ROM address range on command and re-times the registered
// ROM read data onto a valid/ready stream through a 2-entry buffer.
module rom_reader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic         clk,
    input  logic         rst,
    rom_reader_if.slave  bus
);
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] next_addr_r;
    logic [ADDR_W-1:0] last_addr_r;
    logic [CNT_W-1:0]  remain_r;
    logic              inflight_r;
    logic              inflight_last_r;
    logic              done_r;
    logic [DATA_W-1:0] buf_data_r [2];
    logic              buf_last_r [2];
    logic              rd_ptr_r;
    logic              wr_ptr_r;
    logic [1:0]        occ_r;

    logic accept_s;
    logic issue_s;
    logic last_issue_s;
    logic push_s;
    logic pop_s;
    logic last_pop_s;

    // Requests longer than the ROM are truncated to one full sweep.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] req);
        if (req > CNT_W'(DEPTH)) begin
            return CNT_W'(DEPTH);
        end else begin
            return req;
        end
    endfunction

    // Handshake qualifiers and the issue rule shared by the FSM and datapath.
    always_comb begin
        accept_s     = (state_r == ST_IDLE) && bus.start && (bus.count != {CNT_W{1'b0}});
        pop_s        = (occ_r != 2'd0) && bus.out_ready;
        push_s       = inflight_r;
        // Buffered plus in-flight words must never exceed the two buffer slots.
        issue_s      = (state_r == ST_FETCH) &&
                       (({1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s}) < 3'd2);
        last_issue_s = issue_s && (remain_r == CNT_W'(1));
        last_pop_s   = pop_s && buf_last_r[rd_ptr_r];
    end

    // Next-state logic of the transfer sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (last_issue_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (last_pop_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Read address walk, remaining-read count, in-flight tracking and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            next_addr_r     <= {ADDR_W{1'b0}};
            last_addr_r     <= {ADDR_W{1'b0}};
            remain_r        <= {CNT_W{1'b0}};
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            if (accept_s) begin
                next_addr_r <= bus.base_addr;
                remain_r    <= clamp_len(bus.count);
            end else if (issue_s) begin
                // DEPTH is a power of two, so the natural overflow wraps 7 -> 0.
                next_addr_r <= next_addr_r + ADDR_W'(1);
                last_addr_r <= next_addr_r;
                remain_r    <= remain_r - CNT_W'(1);
            end else begin
                next_addr_r <= next_addr_r;
                remain_r    <= remain_r;
            end
            inflight_r      <= issue_s;
            inflight_last_r <= last_issue_s;
            done_r          <= (state_r == ST_DRAIN) && last_pop_s;
        end
    end

    // Two-slot output buffer; ROM data is only written the cycle after an issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                buf_data_r[i] <= {DATA_W{1'b0}};
                buf_last_r[i] <= 1'b0;
            end
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            if (push_s) begin
                buf_data_r[wr_ptr_r] <= bus.rom_data;
                buf_last_r[wr_ptr_r] <= inflight_last_r;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Output drive; rom_addr shows the last issued address between issues.
    always_comb begin
        bus.rom_en    = issue_s;
        bus.rom_addr  = issue_s ? next_addr_r : last_addr_r;
        bus.busy      = (state_r != ST_IDLE);
        bus.done      = done_r;
        bus.out_valid = (occ_r != 2'd0);
        bus.out_data  = buf_data_r[rd_ptr_r];
        bus.out_last  = (occ_r != 2'd0) && buf_last_r[rd_ptr_r];
    end
endmodule
